// File: rtl/fabm_pkg.sv
// Shared constants and types for the fabm partial-product stage.
// The 28-bit product window keeps columns 0..27; higher columns wrap.
package fabm_pkg;

    localparam int WIN_LO = 4;
    localparam int WIN_HI = 27;
    localparam int PW     = 28;
    localparam int PG_W   = WIN_HI - WIN_LO;

    typedef logic [PW-1:0]   row_t;
    typedef logic [PG_W-1:0] pg_t;

    // Baugh-Wooley constant 2^(m+n-1) + 2^(m-1) + 2^(n-1), cut to the window
    function automatic row_t bw_corr(input int aw, input int bw);
        logic [63:0] k;
        k = (64'd1 << (aw + bw - 1)) + (64'd1 << (aw - 1))
          + (64'd1 << (bw - 1));
        return k[PW-1:0];
    endfunction

    localparam row_t BW_CORR = bw_corr(16, 16);
    localparam row_t LO_MASK = ~row_t'(15);

endpackage

// File: rtl/fabm_pp_stage_csa_row.sv
// One row of 3:2 carry-save compressors.
// The carry leaving the top column is dropped (window arithmetic wraps).
module csa_row #(
    parameter int W = 28
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);

    assign s = x ^ y ^ z;
    assign c = {(x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0])
               | (y[W-2:0] & z[W-2:0]), 1'b0};

endmodule

// File: rtl/fabm_pp_stage.sv
// Two-stage Baugh-Wooley partial-product reduction for a 16x16 multiplier.
// Define FABM_APPROX_LSB_EN for OR-approximated product columns 0..3.
module fabm_pp_stage
    import fabm_pkg::*;
#(
    parameter int A_W = 16,
    parameter int B_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output pg_t            prop,
    output pg_t            gen,
    output logic           cin,
    output logic [3:0]     lsb
);

    logic rdy_en;
    logic s1_valid;
    logic s2_valid;
    logic s2_adv;
    logic s1_load;
    logic s2_load;
    logic pp;

    row_t r0 [B_W];
    row_t l1 [11];
    row_t l2 [8];
    row_t l3 [6];
    row_t s1_rows [6];
    row_t l4 [4];
    row_t l5 [3];
    row_t fs;
    row_t fc;

    pg_t        prop_n;
    pg_t        gen_n;
    logic [4:0] low;
    logic [3:0] lsb_n;
    logic       cin_n;

`ifdef FABM_APPROX_LSB_EN
    logic [3:0] lsb_or;
    logic [3:0] s1_lsb;
`endif

    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = rdy_en && (!s1_valid || s2_adv);
    assign s1_load   = in_valid && in_ready;
    assign s2_load   = s2_adv && s1_valid;
    assign out_valid = s2_valid;

    // Partial-product rows; the correction bit sits in row 0's empty column 16
    always_comb begin
        pp = 1'b0;
`ifdef FABM_APPROX_LSB_EN
        lsb_or = '0;
`endif
        for (int i = 0; i < B_W; i++) begin
            r0[i] = '0;
            for (int j = 0; j < A_W; j++) begin
                pp = a[j] & b[i];
                if ((i == B_W - 1) != (j == A_W - 1)) pp = ~pp;
                r0[i] = r0[i] | (row_t'(pp) << (i + j));
`ifdef FABM_APPROX_LSB_EN
                lsb_or = lsb_or | (4'(a[j] & b[i]) << (i + j));
`endif
            end
`ifdef FABM_APPROX_LSB_EN
            r0[i] = r0[i] & LO_MASK;
`endif
        end
        r0[0] = r0[0] | BW_CORR;
    end

    for (genvar k = 0; k < 5; k++) begin : g_l1
        csa_row #(.W(PW)) u_csa (
            .x(r0[3*k]), .y(r0[3*k+1]), .z(r0[3*k+2]),
            .s(l1[2*k]), .c(l1[2*k+1])
        );
    end
    assign l1[10] = r0[15];

    for (genvar k = 0; k < 3; k++) begin : g_l2
        csa_row #(.W(PW)) u_csa (
            .x(l1[3*k]), .y(l1[3*k+1]), .z(l1[3*k+2]),
            .s(l2[2*k]), .c(l2[2*k+1])
        );
    end
    assign l2[6] = l1[9];
    assign l2[7] = l1[10];

    for (genvar k = 0; k < 2; k++) begin : g_l3
        csa_row #(.W(PW)) u_csa (
            .x(l2[3*k]), .y(l2[3*k+1]), .z(l2[3*k+2]),
            .s(l3[2*k]), .c(l3[2*k+1])
        );
    end
    assign l3[4] = l2[6];
    assign l3[5] = l2[7];

    for (genvar k = 0; k < 2; k++) begin : g_l4
        csa_row #(.W(PW)) u_csa (
            .x(s1_rows[3*k]), .y(s1_rows[3*k+1]), .z(s1_rows[3*k+2]),
            .s(l4[2*k]), .c(l4[2*k+1])
        );
    end

    csa_row #(.W(PW)) u_l5 (
        .x(l4[0]), .y(l4[1]), .z(l4[2]),
        .s(l5[0]), .c(l5[1])
    );
    assign l5[2] = l4[3];

    csa_row #(.W(PW)) u_l6 (
        .x(l5[0]), .y(l5[1]), .z(l5[2]),
        .s(fs), .c(fc)
    );

    // Column 27 folds into gen[26]: both weigh 2^27 and the window wraps at 2^28
    always_comb begin
        prop_n     = fs[WIN_HI-1:WIN_LO] ^ fc[WIN_HI-1:WIN_LO];
        gen_n      = fs[WIN_HI-1:WIN_LO] & fc[WIN_HI-1:WIN_LO];
        gen_n[PG_W-1] = gen_n[PG_W-1] ^ fs[WIN_HI] ^ fc[WIN_HI];
        low        = {1'b0, fs[3:0]} + {1'b0, fc[3:0]};
`ifdef FABM_APPROX_LSB_EN
        lsb_n      = s1_lsb;
        cin_n      = 1'b0;
`else
        lsb_n      = low[3:0];
        cin_n      = low[4];
`endif
    end

    // in_ready stays low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    // Stage 1: capture the six rows left after three CSA levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            for (int k = 0; k < 6; k++) s1_rows[k] <= '0;
`ifdef FABM_APPROX_LSB_EN
            s1_lsb <= '0;
`endif
        end else begin
            if (s1_load)     s1_valid <= 1'b1;
            else if (s2_adv) s1_valid <= 1'b0;
            if (s1_load) begin
                for (int k = 0; k < 6; k++) s1_rows[k] <= l3[k];
`ifdef FABM_APPROX_LSB_EN
                s1_lsb <= lsb_or;
`endif
            end
        end
    end

    // Stage 2: register propagate/generate, carry-in and low bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            prop     <= '0;
            gen      <= '0;
            cin      <= 1'b0;
            lsb      <= '0;
        end else begin
            if (s2_adv) s2_valid <= s1_valid;
            if (s2_load) begin
                prop <= prop_n;
                gen  <= gen_n;
                cin  <= cin_n;
                lsb  <= lsb_n;
            end
        end
    end

endmodule

// File: tb/tb_fabm_pp_stage.sv
// Directed bench for fabm_pp_stage: reset, products, streaming,
// backpressure and mid-flight reset.
module tb_fabm_pp_stage;
    import fabm_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    pg_t         prop;
    pg_t         gen;
    logic        cin;
    logic [3:0]  lsb;
    logic [23:0] win;

    int checks = 0;
    int fails  = 0;

    fabm_pp_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .prop(prop), .gen(gen), .cin(cin), .lsb(lsb)
    );

    // Result of the downstream carry-chain adder over columns 26:4
    assign win = {1'b0, prop} + {gen, 1'b0} + {23'd0, cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        checks++; if (prop !== '0) begin fails++; $display("FAIL rst_prop got %h want 0", prop); end
        checks++; if (gen !== '0) begin fails++; $display("FAIL rst_gen got %h want 0", gen); end
        checks++; if (cin !== 1'b0) begin fails++; $display("FAIL rst_cin got %b want 0", cin); end
        checks++; if (lsb !== 4'h0) begin fails++; $display("FAIL rst_lsb got %h want 0", lsb); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rel_in_ready_early got %b want 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic run_vectors(input int nv, input logic [15:0] va [9],
                               input logic [15:0] vb [9], input logic [3:0] el [9],
                               input logic [23:0] ew [9], input int cin_idx);
        int n;
        for (int k = 0; k < nv; k++) begin
            a = va[k]; b = vb[k]; in_valid = 1'b1; out_ready = 1'b1;
            checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL vec%0d_in_ready got %b want 1", k, in_ready); end
            @(negedge clk);
            in_valid = 1'b0;
            n = 0;
            while (out_valid !== 1'b1 && n < 8) begin @(negedge clk); n++; end
            checks++; if (n != 1) begin fails++; $display("FAIL vec%0d_latency got %0d want 1 (8 = timeout)", k, n); end
            checks++; if (lsb !== el[k]) begin fails++; $display("FAIL vec%0d_lsb got %h want %h", k, lsb, el[k]); end
            checks++; if (win !== ew[k]) begin fails++; $display("FAIL vec%0d_window got %h want %h", k, win, ew[k]); end
            if (k == cin_idx) begin
                checks++; if (cin !== 1'b0) begin fails++; $display("FAIL vec%0d_cin got %b want 0", k, cin); end
            end
            @(negedge clk);
        end
    endtask

`ifdef FABM_APPROX_LSB_EN
    task automatic test_approx();
        logic [15:0] va [9];
        logic [15:0] vb [9];
        logic [3:0]  el [9];
        logic [23:0] ew [9];
        va = '{16'h0003, 16'hFFFF, 16'h0003, 0, 0, 0, 0, 0, 0};
        vb = '{16'h0003, 16'h0001, 16'h0005, 0, 0, 0, 0, 0, 0};
        el = '{4'h7, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0};
        ew = '{24'h0, 24'hFFFFFF, 24'h0, 0, 0, 0, 0, 0, 0};
        for (int k = 0; k < 3; k++) begin
            run_vectors(1, '{va[k], 0, 0, 0, 0, 0, 0, 0, 0},
                        '{vb[k], 0, 0, 0, 0, 0, 0, 0, 0},
                        '{el[k], 0, 0, 0, 0, 0, 0, 0, 0},
                        '{ew[k], 0, 0, 0, 0, 0, 0, 0, 0}, 0);
        end
    endtask
`else
    task automatic test_exact();
        logic [15:0] va [9];
        logic [15:0] vb [9];
        logic [3:0]  el [9];
        logic [23:0] ew [9];
        va = '{16'h0003, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h8000,
               16'h0064, 16'hFFFF, 16'h1234, 16'h0123};
        vb = '{16'h0005, 16'h0001, 16'h8000, 16'h7FFF, 16'h7FFF,
               16'hFFFD, 16'hFFFF, 16'h0000, 16'h0045};
        el = '{4'hF, 4'hF, 4'h0, 4'h1, 4'h0, 4'h4, 4'h1, 4'h0, 4'hF};
        ew = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFF000, 24'h000800,
               24'hFFFFED, 24'h000000, 24'h000000, 24'h0004E6};
        run_vectors(9, va, vb, el, ew, 2);
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic [3:0]  el [4];
        logic [23:0] ew [4];
        va = '{16'h000A, 16'hFFFE, 16'h0100, 16'h7FFF};
        vb = '{16'h000A, 16'h0003, 16'h0100, 16'h0002};
        el = '{4'h4, 4'hA, 4'h0, 4'hE};
        ew = '{24'h000006, 24'hFFFFFF, 24'h001000, 24'h000FFF};
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k >= 2) begin
                checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b%0d_valid got %b want 1", k - 2, out_valid); end
                checks++; if (lsb !== el[k-2]) begin fails++; $display("FAIL b2b%0d_lsb got %h want %h", k - 2, lsb, el[k-2]); end
                checks++; if (win !== ew[k-2]) begin fails++; $display("FAIL b2b%0d_window got %h want %h", k - 2, win, ew[k-2]); end
            end
            if (k < 4) begin
                a = va[k]; b = vb[k]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask
`endif

    task automatic test_backpressure();
        logic [3:0] el [3];
        pg_t        hp;
        pg_t        hg;
        logic [3:0] hl;
`ifdef FABM_APPROX_LSB_EN
        el = '{4'h1, 4'h4, 4'h7};
`else
        el = '{4'h1, 4'h4, 4'h9};
`endif
        out_ready = 1'b0;
        a = 16'd1; b = 16'd1; in_valid = 1'b1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_acc1 got %b want 1", in_ready); end
        @(negedge clk);
        a = 16'd2; b = 16'd2;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_acc2 got %b want 1", in_ready); end
        @(negedge clk);
        a = 16'd3; b = 16'd3;
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid got %b want 1", out_valid); end
        hp = prop; hg = gen; hl = lsb;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold%0d_ready got %b want 0", k, in_ready); end
            checks++; if ({prop, gen, lsb} !== {hp, hg, hl}) begin fails++; $display("FAIL bp_hold%0d_stable got %h want %h", k, {prop, gen, lsb}, {hp, hg, hl}); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_res%0d_valid got %b want 1", k, out_valid); end
            checks++; if (lsb !== el[k]) begin fails++; $display("FAIL bp_res%0d_lsb got %h want %h", k, lsb, el[k]); end
            checks++; if (win !== 24'h0) begin fails++; $display("FAIL bp_res%0d_window got %h want 0", k, win); end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        a = 16'd5; b = 16'd7; in_valid = 1'b1;
        @(negedge clk);
        a = 16'd2; b = 16'd3;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_in_ready got %b want 0", in_ready); end
        checks++; if ({prop, gen, cin, lsb} !== '0) begin fails++; $display("FAIL mid_data got %h want 0", {prop, gen, cin, lsb}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_rel_ready got %b want 1", in_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_stale%0d got %b want 0", k, out_valid); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef FABM_APPROX_LSB_EN
        test_approx();
`else
        test_exact();
        test_back_to_back();
`endif
        test_backpressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
